// File: rtl/vdp_bridge_pkg.sv
// Shared types and constants for the Z80-to-VDP I/O bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vdp_bridge_pkg;

  // Bridge sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    CAPTURE = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Default decode: ports 0x00..0x03 when the low two address bits are ignored
  localparam logic [7:0] DEF_PORT_BASE = 8'h01;
  localparam logic [7:0] DEF_PORT_MASK = 8'hFC;

  // Strobe counter width, enough for STROBE_LEN up to 15
  localparam int CNT_W = 4;

  // Value returned to the Z80 when the VDP never flags valid read data
  localparam logic [7:0] FLOAT_DATA = 8'hFF;

  // Address decode: only bits set in mask take part in the compare
  function automatic logic port_hit(input logic [7:0] addr,
                                    input logic [7:0] base,
                                    input logic [7:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/vdp_sync.sv
// N-stage single-bit synchronizer for asynchronous Z80 control pins.
// Latency: STAGES clk cycles from pin change to q.
// Backpressure: none; free-running shift chain.
module vdp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift chain is deliberately not reset: it keeps tracking the pins while
  // the bridge is in reset, so a bus cycle already in flight stays visible
  // afterwards and is not mistaken for a fresh start.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/vdp_z80_bridge.sv
// Turns async Z80 IN/OUT cycles on the VDP port pair into clk40m strobes; optional WAIT stretch via VDP_Z80_WAIT_EN.
// Latency: strobe falls 1 clk after the synchronized start, stays low STROBE_LEN clks.
// Backpressure: Z80 side only, by WAIT when VDP_Z80_WAIT_EN is defined; otherwise none.
module vdp_z80_bridge
  import vdp_bridge_pkg::*;
#(
  parameter logic [7:0] PORT_BASE   = DEF_PORT_BASE,
  parameter logic [7:0] PORT_MASK   = DEF_PORT_MASK,
  parameter int         STROBE_LEN  = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk40m,
  input  logic       rst,
  input  logic [7:0] z80_a,
  input  logic [7:0] z80_d_in,
  output logic [7:0] z80_d_out,
  output logic       z80_d_oe,
  input  logic       z80_iorq_n,
  input  logic       z80_rd_n,
  input  logic       z80_wr_n,
  input  logic       z80_m1_n,
  output logic       z80_wait_n,
  output logic [7:0] cpu_a,
  output logic [7:0] cpu_din,
  input  logic [7:0] cpu_dout,
  input  logic       cpu_doe,
  output logic       cpu_in_n,
  output logic       cpu_out_n
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_LEN - 1);

  // Synchronized, active-high control lines
  logic iorq_s;
  logic rd_s;
  logic wr_s;
  logic m1_s;

  vdp_sync #(.STAGES(SYNC_STAGES)) u_sync_iorq (.clk(clk40m), .d(~z80_iorq_n), .q(iorq_s));
  vdp_sync #(.STAGES(SYNC_STAGES)) u_sync_rd   (.clk(clk40m), .d(~z80_rd_n),   .q(rd_s));
  vdp_sync #(.STAGES(SYNC_STAGES)) u_sync_wr   (.clk(clk40m), .d(~z80_wr_n),   .q(wr_s));
  vdp_sync #(.STAGES(SYNC_STAGES)) u_sync_m1   (.clk(clk40m), .d(~z80_m1_n),   .q(m1_s));

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              is_rd;
  logic              armed;
  logic              start;

  // A new cycle may begin only after IORQ has been seen idle since reset,
  // so a cycle interrupted by reset is never replayed.
  assign start = armed & iorq_s & (rd_s ^ wr_s) & ~m1_s
               & port_hit(z80_a, PORT_BASE, PORT_MASK);

  // State register
  always_ff @(posedge clk40m) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)        state_nxt = STROBE;
      STROBE:  if (cnt == '0)    state_nxt = CAPTURE;
      CAPTURE:                   state_nxt = RELEASE;
      RELEASE: if (!iorq_s)      state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Latches, strobe flops, strobe counter and read-data capture
  always_ff @(posedge clk40m) begin
    if (rst) begin
      cpu_a     <= '0;
      cpu_din   <= '0;
      cpu_in_n  <= 1'b1;
      cpu_out_n <= 1'b1;
      z80_d_out <= '0;
      cnt       <= '0;
      is_rd     <= 1'b0;
      armed     <= 1'b0;
    end else begin
      if (!iorq_s) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            cpu_a     <= z80_a;
            is_rd     <= rd_s;
            cnt       <= CNT_LOAD;
            cpu_in_n  <= ~rd_s;
            cpu_out_n <= ~wr_s;
            if (wr_s) begin
              cpu_din <= z80_d_in;
            end
            // Preload the "no data" value; any valid VDP beat overwrites it
            if (rd_s) begin
              z80_d_out <= FLOAT_DATA;
            end
          end
        end
        STROBE: begin
          if (is_rd && cpu_doe) begin
            z80_d_out <= cpu_dout;
          end
          if (cnt == '0) begin
            cpu_in_n  <= 1'b1;
            cpu_out_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Drive the Z80 data bus only after capture and only while RD is still held
  assign z80_d_oe = ((state == CAPTURE) || (state == RELEASE)) & is_rd & rd_s;

`ifdef VDP_Z80_WAIT_EN
  logic raw_dec;

  // Raw pin decode asserts WAIT before the synchronizers catch up;
  // qualified by IDLE/armed so it cannot hold WAIT after capture or reset.
  assign raw_dec    = ~z80_iorq_n & z80_m1_n & port_hit(z80_a, PORT_BASE, PORT_MASK);
  assign z80_wait_n = ~(((state == IDLE) & armed & raw_dec) | (state == STROBE));
`else
  assign z80_wait_n = 1'b1;
`endif

endmodule

// File: tb/tb_vdp_z80_bridge.sv
// Directed bench for vdp_z80_bridge: write, read, decode filtering, missing data, reset mid-cycle.
// Latency: checks strobe width and 1-clk start latency after synchronization.
// Backpressure: WAIT expectations follow VDP_Z80_WAIT_EN.
`timescale 1ns/1ps
module tb_vdp_z80_bridge;

  logic       clk40m = 1'b0;
  logic       rst;
  logic [7:0] z80_a;
  logic [7:0] z80_d_in;
  logic [7:0] z80_d_out;
  logic       z80_d_oe;
  logic       z80_iorq_n;
  logic       z80_rd_n;
  logic       z80_wr_n;
  logic       z80_m1_n;
  logic       z80_wait_n;
  logic [7:0] cpu_a;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       cpu_doe;
  logic       cpu_in_n;
  logic       cpu_out_n;
  logic       doe_en;

  int vectors = 0;
  int errors  = 0;

`ifdef VDP_Z80_WAIT_EN
  // two sync cycles in IDLE plus four STROBE cycles
  localparam int WAIT_EXP = 6;
`else
  localparam int WAIT_EXP = 0;
`endif

  vdp_z80_bridge dut (
    .clk40m     (clk40m),
    .rst        (rst),
    .z80_a      (z80_a),
    .z80_d_in   (z80_d_in),
    .z80_d_out  (z80_d_out),
    .z80_d_oe   (z80_d_oe),
    .z80_iorq_n (z80_iorq_n),
    .z80_rd_n   (z80_rd_n),
    .z80_wr_n   (z80_wr_n),
    .z80_m1_n   (z80_m1_n),
    .z80_wait_n (z80_wait_n),
    .cpu_a      (cpu_a),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_doe    (cpu_doe),
    .cpu_in_n   (cpu_in_n),
    .cpu_out_n  (cpu_out_n)
  );

  always #5 clk40m = ~clk40m;

  // VDP model: read data valid whenever its read strobe is low
  assign cpu_doe = doe_en & ~cpu_in_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One Z80 I/O cycle held for 'hold' clocks, then released and observed 4 more clocks
  task automatic bus_cycle(input logic [7:0] a, input logic [7:0] d,
                           input bit rd, input bit wr, input bit m1,
                           output int in_low, output int out_low,
                           output int in_edges, output int out_edges,
                           output int wait_low, output bit oe_seen,
                           output logic [7:0] dout_seen, output bit oe_end);
    logic prev_in;
    logic prev_out;
    in_low = 0; out_low = 0; in_edges = 0; out_edges = 0; wait_low = 0;
    oe_seen = 1'b0; dout_seen = 8'h00;
    @(negedge clk40m);
    z80_a      = a;
    z80_d_in   = d;
    z80_iorq_n = 1'b0;
    z80_rd_n   = ~rd;
    z80_wr_n   = ~wr;
    z80_m1_n   = ~m1;
    prev_in    = cpu_in_n;
    prev_out   = cpu_out_n;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk40m);
      if (i == 12) begin
        z80_iorq_n = 1'b1;
        z80_rd_n   = 1'b1;
        z80_wr_n   = 1'b1;
        z80_m1_n   = 1'b1;
      end
      if (!cpu_in_n)  in_low++;
      if (!cpu_out_n) out_low++;
      if (!cpu_in_n && prev_in)   in_edges++;
      if (!cpu_out_n && prev_out) out_edges++;
      if (!z80_wait_n && i < 12) wait_low++;
      if (z80_d_oe) begin
        oe_seen   = 1'b1;
        dout_seen = z80_d_out;
      end
      prev_in  = cpu_in_n;
      prev_out = cpu_out_n;
    end
    oe_end = z80_d_oe;
  endtask

  initial begin
    int         in_low, out_low, in_edges, out_edges, wait_low, cnt_o, cnt_w;
    bit         oe_seen, oe_end;
    logic [7:0] dout_seen;

    rst = 1'b1;
    z80_a = 8'h00; z80_d_in = 8'h00;
    z80_iorq_n = 1'b1; z80_rd_n = 1'b1; z80_wr_n = 1'b1; z80_m1_n = 1'b1;
    cpu_dout = 8'hC3; doe_en = 1'b1;
    repeat (5) @(negedge clk40m);

    chk("rst_d_out",  z80_d_out,  8'h00);
    chk("rst_d_oe",   z80_d_oe,   1'b0);
    chk("rst_wait",   z80_wait_n, 1'b1);
    chk("rst_cpu_a",  cpu_a,      8'h00);
    chk("rst_din",    cpu_din,    8'h00);
    chk("rst_in_n",   cpu_in_n,   1'b1);
    chk("rst_out_n",  cpu_out_n,  1'b1);
    rst = 1'b0;
    repeat (3) @(negedge clk40m);

    // Write 0x5A to port 0x02
    bus_cycle(8'h02, 8'h5A, 0, 1, 0, in_low, out_low, in_edges, out_edges, wait_low, oe_seen, dout_seen, oe_end);
    chk("wr_cpu_a",   cpu_a,     8'h02);
    chk("wr_din",     cpu_din,   8'h5A);
    chk("wr_out_low", out_low,   4);
    chk("wr_out_edg", out_edges, 1);
    chk("wr_in_low",  in_low,    0);
    chk("wr_oe",      oe_seen,   1'b0);
    chk("wr_wait",    wait_low,  WAIT_EXP);

    // Read port 0x01, VDP returns 0xC3
    bus_cycle(8'h01, 8'h00, 1, 0, 0, in_low, out_low, in_edges, out_edges, wait_low, oe_seen, dout_seen, oe_end);
    chk("rd_cpu_a",   cpu_a,     8'h01);
    chk("rd_in_low",  in_low,    4);
    chk("rd_in_edg",  in_edges,  1);
    chk("rd_out_low", out_low,   0);
    chk("rd_oe_seen", oe_seen,   1'b1);
    chk("rd_data",    dout_seen, 8'hC3);
    chk("rd_oe_end",  oe_end,    1'b0);
    chk("rd_wait",    wait_low,  WAIT_EXP);
    chk("rd_din",     cpu_din,   8'h5A);

    // Write to non-matching port 0x10
    bus_cycle(8'h10, 8'hEE, 0, 1, 0, in_low, out_low, in_edges, out_edges, wait_low, oe_seen, dout_seen, oe_end);
    chk("miss_strb",  in_low + out_low, 0);
    chk("miss_cpu_a", cpu_a,     8'h01);
    chk("miss_din",   cpu_din,   8'h5A);

    // Interrupt acknowledge (M1 low with IORQ), RD asserted to isolate the M1 gate
    bus_cycle(8'h02, 8'hEE, 1, 0, 1, in_low, out_low, in_edges, out_edges, wait_low, oe_seen, dout_seen, oe_end);
    chk("ack_strb",   in_low + out_low, 0);
    chk("ack_oe",     oe_seen,   1'b0);
    chk("ack_cpu_a",  cpu_a,     8'h01);

    // RD and WR both asserted: no cycle
    bus_cycle(8'h02, 8'h99, 1, 1, 0, in_low, out_low, in_edges, out_edges, wait_low, oe_seen, dout_seen, oe_end);
    chk("both_strb",  in_low + out_low, 0);
    chk("both_din",   cpu_din,   8'h5A);

    // Read with no valid data from the VDP
    doe_en = 1'b0;
    bus_cycle(8'h03, 8'h00, 1, 0, 0, in_low, out_low, in_edges, out_edges, wait_low, oe_seen, dout_seen, oe_end);
    chk("nod_in_low", in_low,    4);
    chk("nod_oe",     oe_seen,   1'b1);
    chk("nod_data",   dout_seen, 8'hFF);
    doe_en = 1'b1;

    // Reset during the second STROBE cycle of a write
    @(negedge clk40m);
    z80_a = 8'h02; z80_d_in = 8'h77;
    z80_iorq_n = 1'b0; z80_wr_n = 1'b0;
    repeat (4) @(negedge clk40m);
    chk("mid_in_strb", cpu_out_n, 1'b0);
    rst = 1'b1;
    @(negedge clk40m);
    rst = 1'b0;
    chk("mid_out_n",  cpu_out_n,  1'b1);
    chk("mid_wait",   z80_wait_n, 1'b1);
    chk("mid_cpu_a",  cpu_a,      8'h00);
    chk("mid_din",    cpu_din,    8'h00);
    cnt_o = 0; cnt_w = 0;
    repeat (8) begin
      @(negedge clk40m);
      if (!cpu_out_n || !cpu_in_n) cnt_o++;
      if (!z80_wait_n) cnt_w++;
    end
    chk("mid_no_strb", cnt_o, 0);
    chk("mid_no_wait", cnt_w, 0);
    z80_iorq_n = 1'b1; z80_wr_n = 1'b1;
    repeat (4) @(negedge clk40m);

    // Fresh cycle after the interrupted one
    bus_cycle(8'h03, 8'h3C, 0, 1, 0, in_low, out_low, in_edges, out_edges, wait_low, oe_seen, dout_seen, oe_end);
    chk("post_out_low", out_low,   4);
    chk("post_out_edg", out_edges, 1);
    chk("post_cpu_a",   cpu_a,     8'h03);
    chk("post_din",     cpu_din,   8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vdp_z80_bridge.md
Name: vdp_z80_bridge

Overview:
- Upstream neighbour of the VDP top: converts asynchronous Z80 I/O bus cycles into the clean, clk40m-synchronous cpu_in_n/cpu_out_n strobes, cpu_a and cpu_din the VDP consumes.
- Returns cpu_dout to the Z80 data bus.
- Filters decode to the VDP port pair and ignores interrupt-acknowledge cycles.
- Optionally stretches the Z80 cycle with WAIT until read data is captured.

Parameters:
- PORT_BASE, 8'h01, base I/O address of the VDP port pair.
- PORT_MASK, 8'hFC, address bits compared against PORT_BASE; 1 = compared.
- STROBE_LEN, 4, clk40m cycles the VDP strobe stays low; legal range 1..15.
- SYNC_STAGES, 2, synchronizer flops on Z80 control inputs; legal range 2..3.

Ports:
- clk40m  in  1  system clock, 40 MHz.
- rst  in  1  reset, synchronous, active-high.
- z80_a  in  8  Z80 address A7..A0 (asynchronous).
- z80_d_in  in  8  Z80 data bus in (write data).
- z80_d_out  out  8  data driven to Z80 on reads.
- z80_d_oe  out  1  output enable for z80_d_out.
- z80_iorq_n  in  1  Z80 IORQ, async.
- z80_rd_n  in  1  Z80 RD, async.
- z80_wr_n  in  1  Z80 WR, async.
- z80_m1_n  in  1  Z80 M1, async; low with IORQ = interrupt ack.
- z80_wait_n  out  1  WAIT to Z80, active-low.
- cpu_a  out  8  latched port address to VDP.
- cpu_din  out  8  latched write data to VDP.
- cpu_dout  in  8  VDP read data.
- cpu_doe  in  1  VDP read-data valid.
- cpu_in_n  out  1  VDP read strobe, active-low.
- cpu_out_n  out  1  VDP write strobe, active-low.

Behaviour:
- Reset: z80_d_out=0, z80_d_oe=0, z80_wait_n=1, cpu_a=0, cpu_din=0, cpu_in_n=1, cpu_out_n=1, state IDLE, strobe counter 0.
- Sync: iorq/rd/wr/m1 are active-high internally after SYNC_STAGES flops.
- Address and data are sampled from the raw pins in the same cycle the synced start condition is seen. The Z80 holds them stable well before IORQ.
- Start condition: iorq & (rd ^ wr) & ~m1 & ((z80_a & PORT_MASK) == (PORT_BASE & PORT_MASK)).
  - rd and wr both set: treated as no cycle.
  - Non-matching address: ignored.
  - Interrupt ack (M1 low): ignored.
- FSM:
  - IDLE: on start, latch cpu_a; if wr, latch cpu_din; load counter=STROBE_LEN-1; go to STROBE. cpu_in_n/cpu_out_n go low on the next clock edge (1-cycle latency from synced start).
  - STROBE: strobe held low; counter decrements each cycle. At 0, strobe released and go to CAPTURE.
    - For reads, cpu_dout is registered into z80_d_out on every STROBE cycle where cpu_doe=1.
    - The last such value is kept. If cpu_doe was never 1, z80_d_out=8'hFF.
  - CAPTURE: one cycle; z80_wait_n returns high; go to RELEASE.
  - RELEASE: wait until synced iorq=0, then go to IDLE. No new cycle can start until then.
- z80_d_oe = 1 only while state in {CAPTURE, RELEASE}, latched cycle was a read, and synced rd=1. It drops in the cycle after rd deasserts.
- Reset mid-cycle: all outputs return to reset values at once and the FSM goes to IDLE. A Z80 cycle still in progress is not restarted; the FSM waits in IDLE for the next clean start.
- Total strobe width is exactly STROBE_LEN cycles; back-to-back Z80 cycles are separated by at least one IDLE cycle.

Optional Feature:
- Macro VDP_Z80_WAIT_EN.
- Defined:
  - z80_wait_n is driven low combinationally from the raw start decode (iorq & ~m1 & address match, async path) and from STROBE until CAPTURE.
  - Guarantees read data is valid before the Z80 samples it.
- Undefined: z80_wait_n tied to 1; the system clock ratio is relied upon to meet Z80 read timing.

Decomposition:
- Package vdp_bridge_pkg: FSM state enum (IDLE, STROBE, CAPTURE, RELEASE), default port constants, STROBE counter width (4 bits).
- One sub-module, vdp_sync: parameterised N-stage 1-bit synchronizer, instantiated 4 times (iorq, rd, wr, m1).

Test Plan:
- Write: Z80 out to 0x02 with data 0x5A, STROBE_LEN=4 → cpu_a=0x02, cpu_din=0x5A, cpu_out_n low exactly 4 cycles, cpu_in_n stays 1, exactly one strobe.
- Read: Z80 in from 0x01, VDP drives cpu_dout=0xC3 with cpu_doe=1 during strobe → cpu_in_n low 4 cycles, z80_d_out=0xC3, z80_d_oe=1 until rd released, then 0.
- Address 0x10 write, and interrupt ack (iorq+m1 low) → no strobe, all VDP outputs unchanged.
- Read with cpu_doe never asserted → z80_d_out=0xFF.
- rst asserted in the 2nd STROBE cycle → next cycle cpu_out_n=1, z80_wait_n=1; the still-active IORQ produces no strobe until it deasserts and a new cycle starts.
- With VDP_Z80_WAIT_EN, read cycle → z80_wait_n low from IORQ fall through the last STROBE cycle. Without the macro, z80_wait_n=1 throughout.
